// File: rtl/dec_sweep_n.sv
// One-hot write-select generator: single-shot decode of dec_in, or a sweep
// that walks the one-hot across every output (register-file init after reset).
//
// state | meaning
// IDLE  | accepts sweep_start (priority) or dec_en; emits at most one word
// SWEEP | emits onehot(idx) per unheld cycle until idx reaches the last output
module dec_sweep_n #(
   parameter  int SEL_W     = 4,
   parameter  int SKIP_ZERO = 0,
   localparam int OUT_W     = 2 ** SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_en,
   input  logic [SEL_W-1:0] dec_in,
   input  logic             sweep_start,
   input  logic             sweep_hold,
   output logic [OUT_W-1:0] dec_out,
   output logic             dec_valid,
   output logic             busy,
   output logic             sweep_done
);

   localparam int IW = SEL_W + 1;
   localparam logic [IW-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? IW'(1) : IW'(0);
   localparam logic [IW-1:0] LAST_IDX  = IW'(OUT_W - 1);
   localparam logic [IW-1:0] START_IDX = FIRST_IDX + IW'(1);
   localparam bit            SINGLE    = (FIRST_IDX == LAST_IDX);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [OUT_W-1:0] dec_out_q, dec_out_d;
   logic             dec_valid_q, dec_valid_d;
   logic             sweep_done_q, sweep_done_d;

   function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
      logic [OUT_W-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      dec_out_d    = '0;
      dec_valid_d  = 1'b0;
      sweep_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sweep_start) begin
               if (SINGLE) begin
                  // only one output to sweep: finish without leaving IDLE
                  dec_out_d    = onehot(LAST_IDX[SEL_W-1:0]);
                  dec_valid_d  = 1'b1;
                  sweep_done_d = 1'b1;
               end else begin
                  state_d     = SWEEP;
                  dec_out_d   = onehot(FIRST_IDX[SEL_W-1:0]);
                  dec_valid_d = 1'b1;
                  idx_d       = START_IDX;
               end
            end else if (dec_en) begin
               dec_out_d   = onehot(dec_in);
               dec_valid_d = 1'b1;
            end
         end
         SWEEP: begin
            if (!sweep_hold) begin
               dec_out_d   = onehot(idx_q[SEL_W-1:0]);
               dec_valid_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  // leave SWEEP with the last word so a queued dec_en follows with no gap
                  sweep_done_d = 1'b1;
                  state_d      = IDLE;
                  idx_d        = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         dec_out_q    <= '0;
         dec_valid_q  <= 1'b0;
         sweep_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         dec_out_q    <= dec_out_d;
         dec_valid_q  <= dec_valid_d;
         sweep_done_q <= sweep_done_d;
      end
   end

   assign dec_out    = dec_out_q;
   assign dec_valid  = dec_valid_q;
   assign sweep_done = sweep_done_q;
   assign busy       = (state_q == SWEEP);

endmodule

// File: tb/tb_dec_sweep_n.sv
// Bench for dec_sweep_n: two instances (SKIP_ZERO=0 and 1) share stimulus and
// are compared each cycle against a list-of-pending-indices reference model.
module tb_dec_sweep_n;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dec_en = 1'b0;
   logic [3:0]  dec_in = '0;
   logic        sweep_start = 1'b0;
   logic        sweep_hold = 1'b0;
   logic [15:0] dec_out0, dec_out1;
   logic        dec_valid0, dec_valid1, busy0, busy1, done0, done1;

   int n_pass = 0;
   int n_total = 0;

   int          pend[2][16];
   int          npend[2];
   logic [15:0] exp_out[2];
   logic        exp_done[2];
   int          vcnt0, vcnt1, dcnt0;

   always #5 clk = ~clk;

   dec_sweep_n #(.SEL_W(4), .SKIP_ZERO(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .dec_en(dec_en), .dec_in(dec_in),
      .sweep_start(sweep_start), .sweep_hold(sweep_hold),
      .dec_out(dec_out0), .dec_valid(dec_valid0), .busy(busy0), .sweep_done(done0));

   dec_sweep_n #(.SEL_W(4), .SKIP_ZERO(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .dec_en(dec_en), .dec_in(dec_in),
      .sweep_start(sweep_start), .sweep_hold(sweep_hold),
      .dec_out(dec_out1), .dec_valid(dec_valid1), .busy(busy1), .sweep_done(done1));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop(input int k);
      exp_out[k] = 16'(1) << pend[k][0];
      for (int i = 0; i < 15; i++) pend[k][i] = pend[k][i+1];
      npend[k]--;
      if (npend[k] == 0) exp_done[k] = 1'b1;
   endtask

   // A sweep is the list of indices still to be emitted; an empty list is idle.
   task automatic model_step(input int k);
      int first;
      first       = (k == 1) ? 1 : 0;
      exp_out[k]  = '0;
      exp_done[k] = 1'b0;
      if (!rst_n) begin
         npend[k] = 0;
      end else if (npend[k] == 0) begin
         if (sweep_start) begin
            for (int i = first; i < 16; i++) begin
               pend[k][npend[k]] = i;
               npend[k]++;
            end
            pop(k);
         end else if (dec_en) begin
            exp_out[k] = 16'(1) << dec_in;
         end
      end else if (!sweep_hold) begin
         pop(k);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check("d0_out",   dec_out0,          exp_out[0]);
      check("d0_valid", {15'b0, dec_valid0}, {15'b0, exp_out[0] != 16'h0});
      check("d0_busy",  {15'b0, busy0},      {15'b0, npend[0] != 0});
      check("d0_done",  {15'b0, done0},      {15'b0, exp_done[0]});
      check("d1_out",   dec_out1,          exp_out[1]);
      check("d1_valid", {15'b0, dec_valid1}, {15'b0, exp_out[1] != 16'h0});
      check("d1_busy",  {15'b0, busy1},      {15'b0, npend[1] != 0});
      check("d1_done",  {15'b0, done1},      {15'b0, exp_done[1]});
      if (dec_valid0) vcnt0++;
      if (dec_valid1) vcnt1++;
      if (done0) dcnt0++;
   endtask

   initial begin
      npend[0] = 0;
      npend[1] = 0;

      // reset with a pending decode request, then release
      rst_n = 1'b0; dec_en = 1'b1; dec_in = 4'd5;
      cyc();
      cyc();
      check("rst_out", dec_out0, 16'h0000);
      rst_n = 1'b1;
      cyc();
      check("post_rst_out", dec_out0, 16'h0020);

      // exhaustive single decode
      for (int i = 0; i < 16; i++) begin
         dec_in = 4'(i);
         cyc();
         check("single_dec", dec_out0, 16'(1) << i);
      end
      dec_en = 1'b0;
      cyc();
      check("dec_off", dec_out0, 16'h0000);

      // full sweep on both instances
      vcnt0 = 0; vcnt1 = 0; dcnt0 = 0;
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      for (int i = 0; i < 17; i++) cyc();
      check("sweep0_valid_cnt", 16'(vcnt0), 16'd16);
      check("sweep1_valid_cnt", 16'(vcnt1), 16'd15);
      check("sweep0_done_cnt",  16'(dcnt0), 16'd1);

      // SKIP_ZERO sweep held for 3 cycles after 0x0008
      vcnt1 = 0;
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      cyc();
      cyc();
      check("hold_pre", dec_out1, 16'h0008);
      sweep_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("hold_zero", dec_out1, 16'h0000);
      end
      sweep_hold = 1'b0;
      cyc();
      check("hold_resume", dec_out1, 16'h0010);
      for (int i = 0; i < 14; i++) cyc();
      check("hold_valid_cnt", 16'(vcnt1), 16'd15);

      // simultaneous start+decode, decode during busy, decode in done cycle
      sweep_start = 1'b1; dec_en = 1'b1; dec_in = 4'd9;
      cyc();
      check("simul_first", dec_out0, 16'h0001);
      sweep_start = 1'b0; dec_in = 4'd3;
      for (int i = 0; i < 15; i++) cyc();
      check("b2b_last", dec_out0, 16'h8000);
      check("b2b_done", {15'b0, done0}, 16'h0001);
      cyc();
      check("b2b_next", dec_out0, 16'h0008);
      dec_en = 1'b0;
      cyc();

      // reset mid-sweep
      dcnt0 = 0;
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      check("mid_pre", dec_out0, 16'h0040);
      rst_n = 1'b0;
      cyc();
      check("mid_rst_out", dec_out0, 16'h0000);
      rst_n = 1'b1;
      cyc();
      cyc();
      check("mid_no_done", 16'(dcnt0), 16'd0);
      sweep_start = 1'b1;
      cyc();
      sweep_start = 1'b0;
      check("restart", dec_out0, 16'h0001);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         rst_n       = ($urandom_range(0, 79) != 0);
         dec_en      = ($urandom_range(0, 1) != 0);
         dec_in      = 4'($urandom_range(0, 15));
         sweep_start = ($urandom_range(0, 9) == 0);
         sweep_hold  = ($urandom_range(0, 3) == 0);
         cyc();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
